bin_to_digits: RTL and testbench
================================

// Module: bin_to_digits
// PURPOSE
//  Converts an unsigned binary value into six active-low 7-segment digit codes for the LED digit display.
//  Sits directly upstream of the display driver and produces its 48-bit digit_n bus.
//  Uses sequential double-dabble: one bit per cycle, then one encode/blank cycle.
//  Output is registered and holds the last result, so the display never shows a partial conversion.
// PARAMETERS
//  WIDTH   20  width of binary input value; 1..20
//  DIGITS  6   number of decimal digits; the output bus is 8*DIGITS bits
//  BLANK   1   1 = blank leading zeros; 0 = show all digits
// PORTS
//  clk      in   1         system clock; all logic on posedge
//  reset    in   1         synchronous, active-high reset
//  start    in   1         request conversion; sampled only while idle
//  value    in   WIDTH     unsigned binary value, latched when start is accepted
//  dp_mask  in   DIGITS    decimal-point enable per digit (bit i -> digit i), latched with value
//  busy     out  1         conversion in progress
//  done     out  1         one-cycle pulse; digit_n is updated in the same cycle
//  digit_n  out  8*DIGITS  digit i at [8i+7:8i], digit 0 = least significant; bits {dp,g,f,e,d,c,b,a}, 0 = lit
// BEHAVIOUR
//  Reset: state IDLE, busy=0, done=0, digit_n = all 1s (every segment dark); BCD/shift registers cleared.
//  States:
//   - IDLE -> SHIFT on start. value and dp_mask are latched; bit counter = WIDTH.
//   - IDLE -> ENCODE instead of SHIFT if value > 10^DIGITS-1. Overflow flag is set.
//   - SHIFT: each cycle, add 3 to every BCD nibble >= 5, then shift the BCD:value chain left by 1 and decrement the counter.
//     The add-3 and the shift happen in the same cycle. Go to ENCODE when the counter reaches 0, after exactly WIDTH cycles.
//   - ENCODE: one cycle. Registers digit_n, pulses done, returns to IDLE.
//  Latency: start sampled high in cycle 0 -> done=1 and new digit_n in cycle WIDTH+2.
//   On overflow, done=1 in cycle 2.
//  busy=1 from cycle 1 until the cycle before done. busy=0 in the done cycle.
//   A start in the done cycle is accepted.
//  start while busy is ignored and is not queued. value and dp_mask may change freely while busy.
//  Segment codes (dp off): 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90; overflow digit '-'=BF.
//   dp_mask[i]=1 clears bit 7 of digit i.
//  Overflow: every digit shows '-'. dp_mask is still applied.
//  Blanking (BLANK=1): scan from digit DIGITS-1 downward. A zero digit is blanked (FF) until the first digit that is nonzero or has dp set.
//   Digit 0 is never blanked, so value 0 shows "0".
//  Reset mid-conversion aborts immediately: no done pulse, digit_n goes blank.
//  digit_n changes only in the done cycle or on reset.
// TESTING
//  1. value=123456, dp_mask=0 -> done in cycle 22, digit_n=48'hF9A4B0999282, busy low in the same cycle.
//  2. value=0, BLANK=1 -> digit_n=48'hFFFFFFFFFFC0. With BLANK=0 -> 48'hC0C0C0C0C0C0.
//  3. value=1000000 -> done in cycle 2, digit_n=48'hBFBFBFBFBFBF. value=999999 -> 48'h909090909090.
//  4. value=5, dp_mask=6'b000010 -> digit_n=48'hFFFFFFFF4092 (shows "0.5").
//  5. start(7), then start(9) pulsed at cycle 5 -> exactly one done pulse, digit_n=48'hFFFFFFFFFFF8.
//     start(9) in that done cycle -> second done pulse 22 cycles later, digit_n=...FF90.
//  6. start(42), reset at cycle 10 -> busy=0, done never pulses, digit_n all 1s.
//     Then start(42) -> digit_n=48'hFFFFFFFF99A4.

Source files
------------

// File: rtl/bin_to_digits.sv
// rtl/bin_to_digits.sv - sequential double-dabble binary to active-low 7-segment digit converter
module bin_to_digits #(
    parameter int WIDTH  = 20,
    parameter int DIGITS = 6,
    parameter int BLANK  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      value,
    input  logic [DIGITS-1:0]     dp_mask,
    output logic                  busy,
    output logic                  done,
    output logic [8*DIGITS-1:0]   digit_n
);

    localparam int          CW      = $clog2(WIDTH + 1);
    localparam int          BW      = 4 * DIGITS;
    localparam logic [63:0] MAX_VAL = 64'(10 ** DIGITS - 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_ENCODE} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [BW-1:0]       bcd_q, bcd_d;
    logic [WIDTH-1:0]    sr_q, sr_d;
    logic [DIGITS-1:0]   dp_q, dp_d;
    logic                ovf_q, ovf_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [8*DIGITS-1:0] digit_q, digit_d;

    logic [BW-1:0]       bcd_adj;
    logic [BW+WIDTH-1:0] chain;
    logic [8*DIGITS-1:0] enc;
    logic [7:0]          code;
    logic [3:0]          nib;
    logic                lead;

    function automatic logic [7:0] seg7(input logic [3:0] n);
        case (n)
            4'd0:    seg7 = 8'hC0;
            4'd1:    seg7 = 8'hF9;
            4'd2:    seg7 = 8'hA4;
            4'd3:    seg7 = 8'hB0;
            4'd4:    seg7 = 8'h99;
            4'd5:    seg7 = 8'h92;
            4'd6:    seg7 = 8'h82;
            4'd7:    seg7 = 8'hF8;
            4'd8:    seg7 = 8'h80;
            4'd9:    seg7 = 8'h90;
            default: seg7 = 8'hFF;
        endcase
    endfunction

    // Add-3 correction ahead of the shift, both in the same cycle.
    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < DIGITS; i++) begin
            bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                         : bcd_q[4*i +: 4];
        end
        chain = {bcd_adj, sr_q} << 1;
    end

    // Leading-zero blanking scans from the most significant digit down.
    always_comb begin
        enc  = '1;
        code = 8'hFF;
        nib  = 4'd0;
        lead = (BLANK != 0);
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nib  = bcd_q[4*i +: 4];
            code = ovf_q ? 8'hBF : seg7(nib);
            if (dp_q[i]) code[7] = 1'b0;
            if (lead && !ovf_q && nib == 4'd0 && !dp_q[i] && i != 0) begin
                code = 8'hFF;
            end else begin
                lead = 1'b0;
            end
            enc[8*i +: 8] = code;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        sr_d    = sr_q;
        dp_d    = dp_q;
        ovf_d   = ovf_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        digit_d = digit_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sr_d   = value;
                    dp_d   = dp_mask;
                    bcd_d  = '0;
                    cnt_d  = CW'(WIDTH);
                    busy_d = 1'b1;
                    if ({{(64-WIDTH){1'b0}}, value} > MAX_VAL) begin
                        ovf_d   = 1'b1;
                        state_d = S_ENCODE;
                    end else begin
                        ovf_d   = 1'b0;
                        state_d = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                {bcd_d, sr_d} = chain;
                cnt_d         = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = S_ENCODE;
            end
            S_ENCODE: begin
                digit_d = enc;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bcd_q   <= '0;
            sr_q    <= '0;
            dp_q    <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            digit_q <= '1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            sr_q    <= sr_d;
            dp_q    <= dp_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            digit_q <= digit_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign digit_n = digit_q;

endmodule

// File: tb/tb_bin_to_digits.sv
// tb/tb_bin_to_digits.sv - table-driven bench for bin_to_digits, blanking and non-blanking instances
module tb_bin_to_digits;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [19:0] value;
    logic [5:0]  dp_mask;
    logic        busy, done, busy0, done0;
    logic [47:0] digit_n, digit_n0;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    bin_to_digits #(.WIDTH(20), .DIGITS(6), .BLANK(1)) dut (
        .clk(clk), .reset(reset), .start(start), .value(value), .dp_mask(dp_mask),
        .busy(busy), .done(done), .digit_n(digit_n)
    );

    bin_to_digits #(.WIDTH(20), .DIGITS(6), .BLANK(0)) dut_nb (
        .clk(clk), .reset(reset), .start(start), .value(value), .dp_mask(dp_mask),
        .busy(busy0), .done(done0), .digit_n(digit_n0)
    );

    typedef struct {
        logic [19:0] v;
        logic [5:0]  dp;
        int          lat;
        logic [47:0] exp_b;
        logic [47:0] exp_nb;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pulses start for one cycle, returns #1 into cycle 1, then scrambles inputs.
    task automatic do_start(input logic [19:0] v, input logic [5:0] dp);
        @(posedge clk); #1;
        start   = 1'b1;
        value   = v;
        dp_mask = dp;
        @(posedge clk); #1;
        start   = 1'b0;
        value   = 20'($urandom);
        dp_mask = 6'($urandom);
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_vec(input vec_t t, input string tag);
        int lat;
        do_start(t.v, t.dp);
        chk({tag, " busy_c1"}, 64'(busy), 64'd1);
        wait_done(lat);
        chk({tag, " latency"}, 64'(lat), 64'(t.lat));
        chk({tag, " digit_n"}, 64'(digit_n), 64'(t.exp_b));
        chk({tag, " digit_n_noblank"}, 64'(digit_n0), 64'(t.exp_nb));
        chk({tag, " busy_done"}, 64'(busy), 64'd0);
        @(posedge clk); #1;
        chk({tag, " done_one_cycle"}, 64'(done), 64'd0);
        chk({tag, " digit_hold"}, 64'(digit_n), 64'(t.exp_b));
    endtask

    initial begin
        int cyc;
        int lat;
        int seen;

        tbl[0]  = '{20'd123456,  6'b000000, 22, 48'hF9A4B0999282, 48'hF9A4B0999282};
        tbl[1]  = '{20'd0,       6'b000000, 22, 48'hFFFFFFFFFFC0, 48'hC0C0C0C0C0C0};
        tbl[2]  = '{20'd1000000, 6'b000000,  2, 48'hBFBFBFBFBFBF, 48'hBFBFBFBFBFBF};
        tbl[3]  = '{20'd999999,  6'b000000, 22, 48'h909090909090, 48'h909090909090};
        tbl[4]  = '{20'd5,       6'b000010, 22, 48'hFFFFFFFF4092, 48'hC0C0C0C04092};
        tbl[5]  = '{20'hFFFFF,   6'b000001,  2, 48'hBFBFBFBFBF3F, 48'hBFBFBFBFBF3F};
        tbl[6]  = '{20'd42,      6'b000000, 22, 48'hFFFFFFFF99A4, 48'hC0C0C0C099A4};
        tbl[7]  = '{20'd100000,  6'b000000, 22, 48'hF9C0C0C0C0C0, 48'hF9C0C0C0C0C0};
        tbl[8]  = '{20'd7,       6'b000000, 22, 48'hFFFFFFFFFFF8, 48'hC0C0C0C0C0F8};
        tbl[9]  = '{20'd10,      6'b000000, 22, 48'hFFFFFFFFF9C0, 48'hC0C0C0C0F9C0};
        tbl[10] = '{20'd0,       6'b100000, 22, 48'h40C0C0C0C0C0, 48'h40C0C0C0C0C0};

        reset   = 1'b1;
        start   = 1'b0;
        value   = '0;
        dp_mask = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset digit_n", 64'(digit_n), 64'hFFFF_FFFF_FFFF);
        reset = 1'b0;

        for (int i = 0; i < 11; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // start while busy is ignored; start in the done cycle is accepted
        do_start(20'd7, 6'b0);
        cyc = 1;
        while (!done && cyc < 40) begin
            if (cyc == 5) begin
                start = 1'b1;
                value = 20'd9;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk("busy_start latency", 64'(cyc), 64'd22);
        chk("busy_start digit_n", 64'(digit_n), 64'hFFFF_FFFF_FFF8);
        start   = 1'b1;
        value   = 20'd9;
        dp_mask = 6'b0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("done_start no_repeat", 64'(done), 64'd0);
        chk("done_start busy", 64'(busy), 64'd1);
        wait_done(lat);
        chk("done_start latency", 64'(lat), 64'd22);
        chk("done_start digit_n", 64'(digit_n), 64'hFFFF_FFFF_FF90);

        // reset mid-conversion aborts without a done pulse
        do_start(20'd42, 6'b0);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort done", 64'(done), 64'd0);
        chk("abort digit_n", 64'(digit_n), 64'hFFFF_FFFF_FFFF);
        seen = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        chk("abort no_done", 64'(seen), 64'd0);
        run_vec(tbl[6], "after_abort");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
